// File: rtl/fc2_sequencer.sv
// fc2_sequencer: address/control sequencer for the second fully-connected layer.
// Streams k = 0..N_IN-1 to the input buffer and weight ROM, tells the ten
// external accumulators when to load or add, waits out the adder latency,
// then holds the final results until the consumer takes them.
`timescale 1ns/1ps
module fc2_sequencer #(
    parameter int N_IN    = 84,
    parameter int ADDR_W  = 7,
    parameter int ACC_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              out_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_en,
    output logic              acc_clear,
    output logic              busy,
    output logic              out_valid,
    output logic              done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [ADDR_W-1:0] K_LAST     = ADDR_W'(N_IN - 1);
    // DRAIN occupies counts 0..ACC_LAT, i.e. 1 + ACC_LAT cycles
    localparam logic [2:0]        DRAIN_LAST = 3'(ACC_LAT);

    logic [1:0]        state_reg, state_next;
    logic [ADDR_W-1:0] k_reg, k_next;
    logic [2:0]        drain_cnt_reg, drain_cnt_next;
    logic              acc_en_reg, acc_clear_reg;
    logic              issue;
    logic              handshake;

    // A read goes out on every unstalled RUN cycle
    assign issue     = (state_reg == S_RUN) && !stall;
    assign handshake = (state_reg == S_HOLD) && out_ready;

    // Next-state, address and drain-counter logic
    always_comb begin
        state_next     = state_reg;
        k_next         = k_reg;
        drain_cnt_next = drain_cnt_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    k_next     = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    if (k_reg == K_LAST) begin
                        state_next     = S_DRAIN;
                        k_next         = '0;
                        drain_cnt_next = '0;
                    end else begin
                        k_next = k_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next = S_HOLD;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            default: begin
                if (handshake) begin
                    state_next = S_IDLE;
                end
            end
        endcase
    end

    // State registers; accumulate strobes trail the read strobe by one cycle
    // because ROM/buffer data arrives one cycle after the read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            k_reg         <= '0;
            drain_cnt_reg <= '0;
            acc_en_reg    <= 1'b0;
            acc_clear_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            k_reg         <= k_next;
            drain_cnt_reg <= drain_cnt_next;
            acc_en_reg    <= issue;
            acc_clear_reg <= issue && (k_reg == '0);
        end
    end

    assign rd_en     = issue;
    assign rd_addr   = k_reg;
    assign acc_en    = acc_en_reg;
    assign acc_clear = acc_clear_reg;
    assign busy      = (state_reg != S_IDLE);
    assign out_valid = (state_reg == S_HOLD);
    assign done      = handshake;

endmodule

// File: tb/tb_fc2_sequencer.sv
// tb_fc2_sequencer: drives two sequencers (ACC_LAT = 1 and 4) with identical
// stimulus and compares every cycle against a pass-level behavioural model.
`timescale 1ns/1ps
module tb_fc2_sequencer;

    localparam int N_IN   = 84;
    localparam int ADDR_W = 7;
    localparam int TMAX   = 400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic out_ready = 1'b0;

    logic              rd_en_a, acc_en_a, acc_clear_a, busy_a, out_valid_a, done_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic              rd_en_b, acc_en_b, acc_clear_b, busy_b, out_valid_b, done_b;
    logic [ADDR_W-1:0] rd_addr_b;

    int errors = 0;
    int checks = 0;

    // stimulus per pass cycle, and packed observed/expected outputs per DUT
    bit          start_v [TMAX];
    bit          stall_v [TMAX];
    bit          ready_v [TMAX];
    logic [12:0] obs_w   [2][TMAX];
    logic [12:0] exp_w   [2][TMAX];
    int          lat_of  [2] = '{1, 4};

    always #5 clk = ~clk;

    fc2_sequencer #(.N_IN(N_IN), .ADDR_W(ADDR_W), .ACC_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .acc_en(acc_en_a), .acc_clear(acc_clear_a),
        .busy(busy_a), .out_valid(out_valid_a), .done(done_a));

    fc2_sequencer #(.N_IN(N_IN), .ADDR_W(ADDR_W), .ACC_LAT(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .out_ready(out_ready),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .acc_en(acc_en_b), .acc_clear(acc_clear_b),
        .busy(busy_b), .out_valid(out_valid_b), .done(done_b));

    // bit layout: {rd_en, rd_addr[6:0], acc_en, acc_clear, busy, out_valid, done}
    function automatic logic [12:0] pack_a();
        return {rd_en_a, rd_addr_a, acc_en_a, acc_clear_a, busy_a, out_valid_a, done_a};
    endfunction
    function automatic logic [12:0] pack_b();
        return {rd_en_b, rd_addr_b, acc_en_b, acc_clear_b, busy_b, out_valid_b, done_b};
    endfunction

    task automatic clear_stim();
        for (int t = 0; t < TMAX; t++) begin
            start_v[t] = 1'b0;
            stall_v[t] = 1'b0;
            ready_v[t] = 1'b0;
        end
    endtask

    // Apply stimulus cycle by cycle (just after the edge) and record outputs mid-cycle
    task automatic run_stim(input int n);
        for (int t = 0; t < n; t++) begin
            @(posedge clk);
            #1;
            start     = start_v[t];
            stall     = stall_v[t];
            out_ready = ready_v[t];
            @(negedge clk);
            obs_w[0][t] = pack_a();
            obs_w[1][t] = pack_b();
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        stall     = 1'b0;
        out_ready = 1'b0;
    endtask

    // Pass model: a pass begins if start is high at t=0 (sequencer idle). Reads are
    // counted off one per unstalled cycle from t=1; results are final lat+2 cycles
    // after the last read and stay valid until the first ready cycle.
    task automatic build_expect(input int n, input int d);
        int issued, last, hs, addr, lat;
        bit active, rd, ov, dn, bz, prev_rd;
        int prev_addr;
        lat = lat_of[d];
        issued = 0; last = -1; hs = -1; prev_rd = 1'b0; prev_addr = 0;
        active = start_v[0];
        for (int t = 0; t < n; t++) begin
            rd = 1'b0; addr = 0; ov = 1'b0; dn = 1'b0;
            if (active && t >= 1 && issued < N_IN) begin
                addr = issued;
                if (!stall_v[t]) begin
                    rd = 1'b1;
                    issued++;
                    if (issued == N_IN) last = t;
                end
            end
            if (active && last >= 0 && hs < 0 && t >= last + 2 + lat) begin
                ov = 1'b1;
                if (ready_v[t]) begin
                    dn = 1'b1;
                    hs = t;
                end
            end
            bz = active && t >= 1 && (hs < 0 || t == hs);
            exp_w[d][t] = {rd, 7'(addr), prev_rd, prev_rd && (prev_addr == 0), bz, ov, dn};
            prev_rd = rd;
            prev_addr = addr;
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (pack_a() !== 13'h0) begin
            errors++;
            $display("FAIL reset_a got=%h exp=%h", pack_a(), 13'h0);
        end
        checks++;
        if (pack_b() !== 13'h0) begin
            errors++;
            $display("FAIL reset_b got=%h exp=%h", pack_b(), 13'h0);
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        // idle with noise on stall/out_ready: nothing may move
        clear_stim();
        for (int t = 0; t < 10; t++) begin
            stall_v[t] = 1'($urandom_range(0, 1));
            ready_v[t] = 1'($urandom_range(0, 1));
        end
        run_stim(10);
        for (int d = 0; d < 2; d++) begin
            build_expect(10, d);
            for (int t = 0; t < 10; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL reset_idle dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        clear_stim();
        start_v[0] = 1'b1;
        ready_v[90] = 1'b1;
        run_stim(100);
        for (int d = 0; d < 2; d++) begin
            build_expect(100, d);
            for (int t = 0; t < 100; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL basic dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        checks++;
        if (obs_w[0][86][1] !== 1'b0 || obs_w[0][87][1] !== 1'b1) begin
            errors++;
            $display("FAIL basic_ov87 got=%b%b exp=01", obs_w[0][86][1], obs_w[0][87][1]);
        end
        checks++;
        if (obs_w[1][89][1] !== 1'b0 || obs_w[1][90][1] !== 1'b1) begin
            errors++;
            $display("FAIL lat4_ov90 got=%b%b exp=01", obs_w[1][89][1], obs_w[1][90][1]);
        end
        checks++;
        if (obs_w[0][90][0] !== 1'b1 || obs_w[0][91][2] !== 1'b0) begin
            errors++;
            $display("FAIL basic_done90 got done=%b busy91=%b exp 1 0", obs_w[0][90][0], obs_w[0][91][2]);
        end
        $display("test_basic done");
    endtask

    task automatic test_stall();
        clear_stim();
        start_v[0] = 1'b1;
        for (int t = 10; t <= 14; t++) stall_v[t] = 1'b1;
        ready_v[100] = 1'b1;
        run_stim(110);
        for (int d = 0; d < 2; d++) begin
            build_expect(110, d);
            for (int t = 0; t < 110; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL stall dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        checks++;
        if (obs_w[0][12][11:5] !== 7'd9 || obs_w[0][12][12] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got addr=%0d rd_en=%b exp addr=9 rd_en=0", obs_w[0][12][11:5], obs_w[0][12][12]);
        end
        checks++;
        if (obs_w[0][91][1] !== 1'b0 || obs_w[0][92][1] !== 1'b1) begin
            errors++;
            $display("FAIL stall_ov92 got=%b%b exp=01", obs_w[0][91][1], obs_w[0][92][1]);
        end
        $display("test_stall done");
    endtask

    task automatic test_start_busy();
        clear_stim();
        start_v[0] = 1'b1;
        start_v[5] = 1'b1;
        start_v[86] = 1'b1;
        ready_v[95] = 1'b1;
        run_stim(105);
        for (int d = 0; d < 2; d++) begin
            build_expect(105, d);
            for (int t = 0; t < 105; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL start_busy dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        $display("test_start_busy done");
    endtask

    task automatic test_backpressure();
        clear_stim();
        start_v[0] = 1'b1;
        for (int t = 1; t < 80; t++) ready_v[t] = 1'($urandom_range(0, 1));
        ready_v[115] = 1'b1;
        start_v[115] = 1'b1;   // start on the handshake cycle must be ignored
        run_stim(125);
        for (int d = 0; d < 2; d++) begin
            build_expect(125, d);
            for (int t = 0; t < 125; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL backpressure dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        $display("test_backpressure done");
    endtask

    task automatic test_midpass_reset();
        clear_stim();
        start_v[0] = 1'b1;
        run_stim(41);
        for (int d = 0; d < 2; d++) begin
            build_expect(41, d);
            for (int t = 0; t < 41; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL midreset_pre dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        // run_stim returned 1ns after an edge: the DUTs are mid-pass in RUN
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (pack_a() !== 13'h0 || pack_b() !== 13'h0) begin
            errors++;
            $display("FAIL midreset_async got=%h/%h exp=0", pack_a(), pack_b());
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        clear_stim();
        start_v[0] = 1'b1;
        ready_v[95] = 1'b1;
        run_stim(100);
        for (int d = 0; d < 2; d++) begin
            build_expect(100, d);
            for (int t = 0; t < 100; t++) begin
                checks++;
                if (obs_w[d][t] !== exp_w[d][t]) begin
                    errors++;
                    $display("FAIL midreset_post dut%0d t=%0d got=%h exp=%h", d, t, obs_w[d][t], exp_w[d][t]);
                end
            end
        end
        $display("test_midpass_reset done");
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            clear_stim();
            start_v[0] = 1'b1;
            for (int t = 1; t < 150; t++) stall_v[t] = ($urandom_range(0, 3) == 0);
            for (int t = 150; t < 300; t++) stall_v[t] = 1'($urandom_range(0, 1));
            for (int t = 1; t < 290; t++) ready_v[t] = ($urandom_range(0, 2) == 0);
            for (int t = 290; t < 300; t++) ready_v[t] = 1'b1;
            run_stim(300);
            for (int d = 0; d < 2; d++) begin
                build_expect(300, d);
                for (int t = 0; t < 300; t++) begin
                    checks++;
                    if (obs_w[d][t] !== exp_w[d][t]) begin
                        errors++;
                        $display("FAIL random%0d dut%0d t=%0d got=%h exp=%h", it, d, t, obs_w[d][t], exp_w[d][t]);
                    end
                end
            end
            $display("test_random iteration %0d done", it);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_start_busy();
        test_backpressure();
        test_midpass_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
